// File: rtl/logic_sweep_checker.sv
// Exhaustive 2-bit AND/OR sweep checker: drives all 16 x/y vectors, counts failing responses.
// Optional macro LOGIC_SWEEP_FIRST_FAIL_EN captures the index of the first failing vector.
module logic_sweep_checker #(
  parameter int STIM_DELAY = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic [1:0] x_out,
  output logic [1:0] y_out,
  input  logic [1:0] and_in,
  input  logic [1:0] or_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] fail_idx,
  output logic       fail_valid
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  localparam logic [7:0] DELAY = 8'(STIM_DELAY);

  state_t     state_q, state_d;
  logic [3:0] v_q, v_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] err_q, err_d;
  logic       launch;
  logic       vec_fail;

  // A new sweep may only be launched from a quiescent state; start while busy is ignored.
  assign launch   = start && (state_q == IDLE || state_q == DONE);
  assign vec_fail = (and_in != (x_out & y_out)) || (or_in != (x_out | y_out));

  assign x_out     = v_q[3:2];
  assign y_out     = v_q[1:0];
  assign err_count = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      v_q     <= 4'd0;
      cnt_q   <= 8'd0;
      err_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (launch) state_d = DRIVE;
      DRIVE:      if (cnt_q <= 8'd1) state_d = CHECK;
      CHECK:      state_d = (v_q == 4'd15) ? DONE : DRIVE;
      default:    state_d = IDLE;
    endcase
  end

  // Counter loads STIM_DELAY on entry to DRIVE, so DRIVE lasts exactly STIM_DELAY cycles.
  always_comb begin
    v_d   = v_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (launch) begin
      v_d   = 4'd0;
      cnt_d = DELAY;
      err_d = 5'd0;
    end else if (state_q == DRIVE) begin
      cnt_d = cnt_q - 8'd1;
    end else if (state_q == CHECK) begin
      if (vec_fail) err_d = err_q + 5'd1;
      if (v_q != 4'd15) begin
        v_d   = v_q + 4'd1;
        cnt_d = DELAY;
      end
    end
  end

  always_comb begin
    busy = (state_q == DRIVE) || (state_q == CHECK);
    done = (state_q == DONE);
    pass = done && (err_q == 5'd0);
  end

`ifdef LOGIC_SWEEP_FIRST_FAIL_EN
  logic [3:0] fidx_q, fidx_d;
  logic       fvld_q, fvld_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fidx_q <= 4'd0;
      fvld_q <= 1'b0;
    end else begin
      fidx_q <= fidx_d;
      fvld_q <= fvld_d;
    end
  end

  always_comb begin
    fidx_d = fidx_q;
    fvld_d = fvld_q;
    if (launch) begin
      fidx_d = 4'd0;
      fvld_d = 1'b0;
    end else if (state_q == CHECK && vec_fail && !fvld_q) begin
      fidx_d = v_q;
      fvld_d = 1'b1;
    end
  end

  assign fail_idx   = fidx_q;
  assign fail_valid = fvld_q;
`else
  assign fail_idx   = 4'd0;
  assign fail_valid = 1'b0;
`endif

endmodule
